// File: rtl/sync_fifo_wr_arbiter_pkg.sv
// Shared constants and helpers for the FIFO write arbiter slice.
package sync_fifo_wr_arbiter_pkg;

    localparam int N     = 16;            // payload width per requester
    localparam int REQ   = 4;             // number of requesters
    localparam int REQ_N = $clog2(REQ);   // requester ID width
    localparam int DEPTH = 4;             // depth of the attached FIFO
    localparam int D_N   = 2;             // FIFO pointer / credit width

    // The FIFO reports full at DEPTH-1 entries, so that is the usable capacity.
    localparam logic [D_N-1:0] CREDIT_MAX = D_N'(DEPTH - 1);

    // Width of a tagged FIFO word {ID, payload}.
    localparam int W_N = REQ_N + N;

    // Extract requester idx's payload from the packed request bus.
    function automatic logic [N-1:0] req_slice(input logic [REQ*N-1:0] data,
                                               input logic [REQ_N-1:0] idx);
        return data[idx*N +: N];
    endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_rr_priority_select.sv
// Round-robin priority selector: first valid bit at or above ptr, wrapping.
// Purely combinational so other arbiters can reuse it.
module rr_priority_select #(
    parameter int REQ   = 4,
    parameter int REQ_N = 2
) (
    input  logic [REQ-1:0]   valid,
    input  logic [REQ_N-1:0] ptr,
    output logic [REQ-1:0]   grant,
    output logic [REQ_N-1:0] idx,
    output logic             any_valid
);

    logic [REQ_N-1:0] cand;

    // Scan REQ candidates starting from ptr and keep the first valid one.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < REQ; i++) begin
            cand = REQ_N'((int'(ptr) + i) % REQ);
            if (!any_valid && valid[cand]) begin
                any_valid   = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a shared sync FIFO. Grants at most one
// requester per cycle, registers its word and writes it to the FIFO next cycle,
// using a credit counter so the FIFO can never be overrun.
module sync_fifo_wr_arbiter
    import sync_fifo_wr_arbiter_pkg::*;
(
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iREMOVE,
    input  logic [REQ-1:0]       iREQ_VALID,
    input  logic [REQ*N-1:0]     iREQ_DATA,
    output logic [REQ-1:0]       oREQ_ACK,
    output logic                 oFIFO_REMOVE,
    output logic                 oFIFO_WR_EN,
    output logic [REQ_N+N-1:0]   oFIFO_WR_DATA,
    input  logic                 iFIFO_RD_EN,
    input  logic                 iFIFO_WR_FULL,
    output logic [D_N-1:0]       oCREDIT,
    output logic                 oOVERFLOW_ERR
);

    logic [D_N-1:0]   credit;
    logic [REQ_N-1:0] ptr;
    logic             stage_valid;
    logic [W_N-1:0]   stage_data;
    logic             remove_q;
    logic             overflow_err;

    logic [REQ-1:0]   sel_grant;
    logic [REQ_N-1:0] win_idx;
    logic             any_valid;
    logic             eligible;
    logic             fire;
    logic             pop;

    rr_priority_select #(
        .REQ   (REQ),
        .REQ_N (REQ_N)
    ) u_sel (
        .valid     (iREQ_VALID),
        .ptr       (ptr),
        .grant     (sel_grant),
        .idx       (win_idx),
        .any_valid (any_valid)
    );

    // A grant needs a free slot and no flush in progress; pops are ignored in
    // the flush cycle and the one after, while the FIFO itself is clearing.
    assign eligible = (credit != '0) && !iREMOVE;
    assign fire     = eligible && any_valid;
    assign pop      = iFIFO_RD_EN && !iREMOVE && !remove_q;

    assign oREQ_ACK      = fire ? sel_grant : '0;
    assign oFIFO_WR_EN   = stage_valid;
    assign oFIFO_WR_DATA = stage_data;
    assign oFIFO_REMOVE  = remove_q;
    assign oCREDIT       = credit;
    assign oOVERFLOW_ERR = overflow_err;

    // Stage register and round-robin pointer: capture the winner's tagged word.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            // NOTE: the data register is reset too, because the FIFO write-data output must read 0 out of reset.
            stage_valid <= 1'b0;
            stage_data  <= '0;
            ptr         <= '0;
        end else if (iREMOVE) begin
            stage_valid <= 1'b0;
            ptr         <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            stage_valid <= fire;
            if (fire) begin
                stage_data <= {win_idx, req_slice(iREQ_DATA, win_idx)};
                ptr        <= (win_idx == REQ_N'(REQ - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

    // Credit counter: grant consumes a slot, pop returns one, saturating at the top.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            credit <= CREDIT_MAX;
        end else if (iREMOVE) begin
            credit <= CREDIT_MAX;
        end else if (fire && !pop) begin
            credit <= credit - 1'b1;
        end else if (pop && !fire && (credit != CREDIT_MAX)) begin
            credit <= credit + 1'b1;
        end
    end

    // Sticky overflow: write into a full FIFO, or a pop the credits cannot account for.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            overflow_err <= 1'b0;
        end else if ((stage_valid && iFIFO_WR_FULL) ||
                     (pop && !fire && (credit == CREDIT_MAX))) begin
            overflow_err <= 1'b1;
        end
    end

    // Flush request forwarded to the FIFO one cycle later.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            remove_q <= 1'b0;
        end else begin
            remove_q <= iREMOVE;
        end
    end

endmodule

// File: doc/sync_fifo_wr_arbiter.md
Name: sync_fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one sync_fifo instance between REQ independent producers.
- Accepts one word per cycle from the winning requester and registers it.
- Writes it into the FIFO one cycle later, tagged with the requester ID.
- Tracks FIFO occupancy with its own credit counter, so no grant can ever overflow the FIFO; sits directly in front of the FIFO write port.

Parameters:
- N, 16, payload width per requester.
- REQ, 4, number of requesters.
- REQ_N, 2, requester ID width; REQ_N = clog2(REQ).
- DEPTH, 4, depth of the attached FIFO.
- D_N, 2, FIFO pointer width; DEPTH = 2**D_N.

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  reset, asynchronous, active-low
- iREMOVE  in  1  synchronous flush of arbiter and FIFO
- iREQ_VALID  in  REQ  per-requester write request; held with data until acked
- iREQ_DATA  in  REQ*N  packed payloads; requester k at [k*N +: N]
- oREQ_ACK  out  REQ  one-hot grant; data taken this cycle
- oFIFO_REMOVE  out  1  registered copy of iREMOVE, to FIFO iREMOVE
- oFIFO_WR_EN  out  1  FIFO write strobe
- oFIFO_WR_DATA  out  REQ_N+N  {ID, payload}
- iFIFO_RD_EN  in  1  FIFO pop, from consumer, same signal driven to FIFO
- iFIFO_WR_FULL  in  1  FIFO full flag, checking only
- oCREDIT  out  D_N  free slots remaining
- oOVERFLOW_ERR  out  1  sticky error

Behaviour:
- Reset values:
  - All outputs 0, except oCREDIT = DEPTH-1.
  - Round-robin pointer = 0; stage register empty.
- Credits:
  - Usable capacity is DEPTH-1, matching the FIFO full flag, which asserts at DEPTH-1 entries.
  - Per cycle: grant and no pop → credit-1; pop and no grant → credit+1; both or neither → unchanged.
  - A pop with credit already at DEPTH-1 is ignored: credit saturates and oOVERFLOW_ERR is set.
- Arbitration (combinational, cycle t):
  - Eligible when credit != 0 and iREMOVE = 0.
  - Winner is the first asserted iREQ_VALID bit, searching upward from the pointer with wrap REQ-1 → 0.
  - oREQ_ACK[winner] = 1 in cycle t; the payload and ID are captured at the cycle-t clock edge.
  - The pointer is updated to winner+1 mod REQ at that edge.
  - No valid requests → no ack, pointer held.
- Write stage:
  - oFIFO_WR_EN = 1 in cycle t+1 with the captured {ID, payload}. Latency request → FIFO write is 1 cycle.
  - The stage is a pure register; back-to-back grants give back-to-back writes.
  - Throughput is 1 word/cycle while credit remains.
- Requester rule: after an ack, a requester may present a new word on the very next cycle.
  - Starvation bound: a continuously valid requester is acked within REQ eligible cycles.
- Flush (iREMOVE = 1 in cycle t):
  - No ack in cycle t; any stage contents are discarded, so oFIFO_WR_EN = 0 in t+1.
  - Credit returns to DEPTH-1 and the pointer returns to 0 at the edge.
  - oFIFO_REMOVE = 1 in t+1.
  - iFIFO_RD_EN is ignored in cycles t and t+1.
  - oOVERFLOW_ERR is cleared only by reset.
- Error: oOVERFLOW_ERR is set if oFIFO_WR_EN and iFIFO_WR_FULL are both 1 in the same cycle, or on a pop at saturated credit.
- Reset mid-operation: async clear of everything, including a pending stage write, within the same cycle.
- Width rules: credit is D_N bits, with no wrap permitted; ID is the winner index truncated to REQ_N bits.

Decomposition:
- Shared package holds:
  - packed-data slice helper;
  - credit-limit constant DEPTH-1;
  - ID width derivation.
- One natural sub-module: rr_priority_select.
  - Inputs: valid vector and pointer.
  - Outputs: one-hot grant, winner index and any_valid.
  - Purely combinational, reused by other arbiters.
- Credit counter and stage register stay in the top.

Test Plan:
1. Reset, then requester 2 alone, valid with data 0x1234 → ack[2] in cycle 0; WR_EN with {2'd2, 0x1234} in cycle 1; credit 3 → 2.
2. All 4 valid continuously, no pops, DEPTH = 4 → acks in order 0, 1, 2, then stall; credit reaches 0; no 4th ack; WR_FULL never coincides with WR_EN.
3. Credit 0, then a single iFIFO_RD_EN → credit 1; next cycle ack goes to requester 3, the pointer continuing from 3.
4. Simultaneous grant and pop at credit 2 → credit stays 2; FIFO count unchanged afterwards.
5. iREMOVE in the same cycle as valid on requester 1 with credit 1 → no ack, no WR_EN next cycle, FIFO_REMOVE pulses once; credit 3, pointer 0.
6. Pop injected at credit 3 → credit stays 3, oOVERFLOW_ERR = 1 and stays set until inRESET.
